// File: rtl/bkadd_seq.sv
// bkadd_seq: sequences one wide add/subtract through a narrow, shared
// multi-cycle adder, one slice at a time from the least significant slice.
// The carry out of each slice is fed back as the carry in of the next.
// The finished result is held until the consumer takes it.

module bkadd_seq #(
    parameter int SW      = 16,
    parameter int NSLICE  = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SW*NSLICE-1:0] req_a,
    input  logic [SW*NSLICE-1:0] req_b,
    input  logic                 req_cin,
    input  logic                 req_sub,

    output logic [SW-1:0]        add_a,
    output logic [SW-1:0]        add_b,
    output logic                 add_cin,
    input  logic [SW-1:0]        add_s,
    input  logic                 add_cout,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [SW*NSLICE-1:0] rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf
);

    localparam int OW = SW * NSLICE;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Index of the most significant slice and the last wait cycle of a slice.
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);
    localparam logic [3:0]    C_LAST = 4'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    // Operands are kept as arrays of slices so the active slice can be
    // picked out directly by the slice index.
    logic [NSLICE-1:0][SW-1:0] a_q;
    logic [NSLICE-1:0][SW-1:0] b_q;
    logic                      cin0_q;

    logic [NSLICE-1:0][SW-1:0] sum_q;
    logic                      carry_q;

    logic [KW-1:0]             k_q;
    logic [3:0]                cnt_q;

    logic                      accept;
    logic                      slice_done;
    logic                      last_slice;

    // A request is taken only while idle; the adder result is trusted only
    // once the slice inputs have been held for the full adder latency.
    assign accept     = (state_q == IDLE) && req_valid;
    assign slice_done = (state_q == RUN) && (cnt_q == C_LAST);
    assign last_slice = (k_q == K_LAST);

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode plus handshake and shared-adder drive.
    always_comb begin
        state_nxt = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                add_a   = a_q[k_q];
                add_b   = b_q[k_q];
                add_cin = (k_q == '0) ? cin0_q : carry_q;
                if (slice_done && last_slice) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture at accept; subtraction is folded into an add of the
    // inverted B with a forced carry-in of one.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            cin0_q <= 1'b0;
        end else if (accept) begin
            a_q    <= req_a;
            b_q    <= req_sub ? ~req_b : req_b;
            cin0_q <= req_sub ? 1'b1 : req_cin;
        end
    end

    // Slice index and per-slice wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            k_q   <= '0;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            if (slice_done) begin
                k_q   <= last_slice ? '0 : k_q + KW'(1);
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    // Result slice and running carry are written when the adder output
    // for the current slice is known to have settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (slice_done) begin
            sum_q[k_q] <= add_s;
            carry_q    <= add_cout;
        end
    end

    // The carry out of the top slice is the final carry; signed overflow
    // means both effective operands agree in sign and the sum does not.
    always_comb begin
        rsp_sum  = sum_q;
        rsp_cout = carry_q;
        rsp_ovf  = (a_q[NSLICE-1][SW-1] == b_q[NSLICE-1][SW-1]) &&
                   (sum_q[NSLICE-1][SW-1] != a_q[NSLICE-1][SW-1]);
    end

    // Flat operand width kept for readers cross-checking port widths.
    logic [OW-1:0] unused_ow_ref;
    assign unused_ow_ref = '0;

endmodule

// File: tb/tb_bkadd_seq.sv
// tb_bkadd_seq: directed test of the sliced add/subtract sequencer with a
// latency-aware adder model and a transaction-level reference model.

module tb_bkadd_seq;

    localparam int SW      = 16;
    localparam int NSLICE  = 4;
    localparam int ADD_LAT = 2;
    localparam int OW      = SW * NSLICE;
    localparam int PERIOD  = 10;
    localparam int LAT     = NSLICE * ADD_LAT;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [OW-1:0] req_a;
    logic [OW-1:0] req_b;
    logic          req_cin;
    logic          req_sub;
    logic [SW-1:0] add_a;
    logic [SW-1:0] add_b;
    logic          add_cin;
    logic [SW-1:0] add_s;
    logic          add_cout;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [OW-1:0] rsp_sum;
    logic          rsp_cout;
    logic          rsp_ovf;

    int checks = 0;
    int errors = 0;

    bkadd_seq #(
        .SW      (SW),
        .NSLICE  (NSLICE),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #(PERIOD / 2) clk = ~clk;
    end

    // Shared adder model: its output is only correct once the inputs have
    // been stable for ADD_LAT cycles; before that it returns inverted data.
    time last_change = 0;
    logic add_ok = 1'b0;
    logic [SW:0] true_sum;

    always @(add_a or add_b or add_cin) begin
        last_change = $time;
        add_ok      = 1'b0;
    end

    always @(negedge clk) begin
        add_ok = (($time - last_change) > time'((ADD_LAT - 1) * PERIOD));
    end

    assign true_sum = {1'b0, add_a} + {1'b0, add_b} + {{SW{1'b0}}, add_cin};
    assign {add_cout, add_s} = add_ok ? true_sum : ~true_sum;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: tracks the handshake at transaction level and works
    // out each result with plain wide arithmetic.
    bit            m_live  = 1'b0;
    bit            m_ready = 1'b0;
    bit            m_valid = 1'b0;
    int            m_count = 0;
    logic [OW-1:0] m_sum   = '0;
    logic          m_cout  = 1'b0;
    logic          m_ovf   = 1'b0;

    always @(posedge clk) begin
        logic [OW-1:0] beff;
        logic [OW:0]   full;
        if (rst) begin
            m_live  = 1'b1;
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_count = 0;
        end else if (m_live) begin
            if (m_ready && req_valid) begin
                beff    = req_sub ? ~req_b : req_b;
                full    = {1'b0, req_a} + {1'b0, beff} + {{OW{1'b0}}, (req_sub | req_cin)};
                m_sum   = full[OW-1:0];
                m_cout  = full[OW];
                m_ovf   = (req_a[OW-1] == beff[OW-1]) && (full[OW-1] != req_a[OW-1]);
                m_ready = 1'b0;
                m_count = LAT;
            end else if (m_count > 0) begin
                m_count--;
                if (m_count == 0) m_valid = 1'b1;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (m_live) begin
            check_output("req_ready", 64'(req_ready), 64'(m_ready));
            check_output("rsp_valid", 64'(rsp_valid), 64'(m_valid));
            if (m_valid) begin
                check_output("rsp_sum", rsp_sum, m_sum);
                check_output("rsp_cout", 64'(rsp_cout), 64'(m_cout));
                check_output("rsp_ovf", 64'(rsp_ovf), 64'(m_ovf));
            end
            if (m_count == 0) begin
                check_output("add_a idle", 64'(add_a), 64'd0);
                check_output("add_b idle", 64'(add_b), 64'd0);
                check_output("add_cin idle", 64'(add_cin), 64'd0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one request and waits (bounded) for it to be accepted.
    task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub);
        bit got;
        got       = 1'b0;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_sub   = sub;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            got = req_ready;
            tick();
        end
        if (!got) check_output("accept timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    // Counts cycles from the accepting edge until the response appears.
    task automatic wait_response(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            lat++;
            seen = rsp_valid;
        end
        if (!seen) check_output("response timeout", 64'd0, 64'd1);
    endtask

    task automatic expect_result(input string name, input logic [63:0] sum,
                                 input logic cout, input logic ovf);
        int lat;
        wait_response(lat);
        check_output({name, " latency"}, 64'(lat), 64'(LAT));
        check_output({name, " sum"}, rsp_sum, sum);
        check_output({name, " cout"}, 64'(rsp_cout), 64'(cout));
        check_output({name, " ovf"}, 64'(rsp_ovf), 64'(ovf));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        req_sub   = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check_output("reset req_ready", 64'(req_ready), 64'd1);
        check_output("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("reset rsp_sum", rsp_sum, 64'd0);
        check_output("reset rsp_cout", 64'(rsp_cout), 64'd0);
        check_output("reset rsp_ovf", 64'(rsp_ovf), 64'd0);
        tick();

        apply_stimulus(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
        expect_result("slice carry", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        tick();

        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        expect_result("full ripple", 64'd0, 1'b1, 1'b0);

        apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        expect_result("signed ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        apply_stimulus(64'd5, 64'd7, 1'b0, 1'b1);
        expect_result("sub borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

        apply_stimulus(64'd7, 64'd5, 1'b1, 1'b1);
        expect_result("sub no borrow", 64'd2, 1'b1, 1'b0);

        // Back-pressure with a second request waiting; operands change
        // while the first operation is running.
        apply_stimulus(64'd10, 64'd20, 1'b0, 1'b0);
        req_a     = 64'd100;
        req_b     = 64'd23;
        req_sub   = 1'b1;
        req_valid = 1'b1;
        begin
            int lat;
            wait_response(lat);
            check_output("stall latency", 64'(lat), 64'(LAT));
        end
        for (int i = 0; i < 3; i++) begin
            check_output("stall req_ready", 64'(req_ready), 64'd0);
            check_output("stall rsp_sum", rsp_sum, 64'd30);
            check_output("stall rsp_valid", 64'(rsp_valid), 64'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("reentry req_ready", 64'(req_ready), 64'd1);
        check_output("reentry rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        req_valid = 1'b0;
        check_output("second accepted", 64'(req_ready), 64'd0);
        expect_result("second req", 64'd77, 1'b1, 1'b0);

        // Reset three cycles into an operation discards it.
        apply_stimulus(64'h1234, 64'd1, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("abort req_ready", 64'(req_ready), 64'd1);
        check_output("abort rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("abort rsp_sum", rsp_sum, 64'd0);
        check_output("abort add_a", 64'(add_a), 64'd0);
        for (int i = 0; i < 12; i++) begin
            check_output("abort no response", 64'(rsp_valid), 64'd0);
            tick();
        end
        apply_stimulus(64'd1, 64'd2, 1'b0, 1'b0);
        expect_result("after abort", 64'd3, 1'b0, 1'b0);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #(PERIOD * 20000);
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
